out_display_unit: RTL

- Sits directly downstream of the processor core and consumes its OUT-instruction outputs (outdisplay, outsel, outval1).
- Latches each OUT value into one of 8 16-bit display slots, indexed by outsel.
- Drives an 8-digit multiplexed, active-low seven-segment display showing two slots at a time, chosen by a page input.
- Drives per-slot "written" LEDs.

---
 rtl/out_display_pkg.sv | 19 +
 rtl/out_display_unit_hex_to_seg.sv | 14 +
 rtl/out_display_unit.sv | 94 +++++++++
 3 files changed

// File: rtl/out_display_pkg.sv
// Shared constants and segment table for the OUT display unit.
// Segment values are active-low, gfedcba order.
package out_display_pkg;

  localparam int NUM_SLOTS  = 8;
  localparam int NUM_DIGITS = 8;

  localparam logic [7:0] SEG_OFF  = 8'hFF;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  // Entry n is the glyph for hex digit n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/out_display_unit_hex_to_seg.sv
// Hex nibble to active-low seven-segment decoder.
// Purely combinational.
module hex_to_seg
  import out_display_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = HEX_SEG[nib];
  end

endmodule

// File: rtl/out_display_unit.sv
// Captures core OUT values into 8 slots and scans them
// onto an 8-digit multiplexed seven-segment display.
module out_display_unit
  import out_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        outdisplay,
  input  logic [2:0]  outsel,
  input  logic [15:0] outval1,
  input  logic [1:0]  page,
  output logic [7:0]  seg,
  output logic [7:0]  an,
  output logic [7:0]  led
);

  localparam int PW =
    (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX =
    PW'(REFRESH_DIV - 1);

  logic [15:0]    slot_q [NUM_SLOTS];
  logic [15:0]    slot_d [NUM_SLOTS];
  logic [7:0]     written_q, written_d;
  logic [2:0]     idx_q, idx_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [7:0]     seg_q, seg_d;
  logic [7:0]     an_q, an_d;

  logic [2:0]     sel_slot;
  logic [15:0]    sel_val;
  logic [3:0]     nib;
  logic [6:0]     hex_seg;

  hex_to_seg u_hex (
    .nib (nib),
    .seg (hex_seg)
  );

  always_comb begin
    slot_d    = slot_q;
    written_d = written_q;
    if (outdisplay) begin
      slot_d[outsel]    = outval1;
      written_d[outsel] = 1'b1;
    end
  end

  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      idx_d   = idx_q + 3'd1;
    end
  end

  // Digits 7..4 show the odd slot of the page pair.
  always_comb begin
    sel_slot = {page, idx_q[2]};
    sel_val  = slot_q[sel_slot];
    nib      = 4'(sel_val >> {idx_q[1:0], 2'b00});
    seg_d    = {1'b1, SEG_DASH};
    if (written_q[sel_slot]) begin
      seg_d = {1'b1, hex_seg};
    end
    an_d = ~(8'd1 << idx_q);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      slot_q    <= '{default: '0};
      written_q <= '0;
      idx_q     <= '0;
      presc_q   <= '0;
      seg_q     <= SEG_OFF;
      an_q      <= 8'hFF;
    end else begin
      slot_q    <= slot_d;
      written_q <= written_d;
      idx_q     <= idx_d;
      presc_q   <= presc_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign led = written_q;

endmodule
